// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared stage indices, stall bus width and hazard FSM states
package pipe_hazard_ctrl_pkg;
   localparam int STALL_W   = 6;
   localparam int STAGE_IF  = 0;
   localparam int STAGE_ID  = 1;
   localparam int STAGE_EX  = 2;
   localparam int STAGE_MEM = 3;
   localparam int STAGE_WB  = 4;
   typedef enum logic [1:0] {RUN, TIMED, FLUSH_WAIT, FLUSH} state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_prio.sv
// prio_stall_mask: highest requesting stage -> thermometer stall mask plus one-hot bubble above it
module prio_stall_mask #(
   parameter int N = 6
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] mask,
   output logic [N-1:0] bub
);
   assign bub[0] = 1'b0;
   for (genvar i = 0; i < N; i++) begin : g_mask
      assign mask[i] = |req[N-1:i];
      if (i > 0) begin : g_bub
         assign bub[i] = mask[i-1] & ~mask[i];
      end
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: merges stage stalls, timed EX stalls and flush requests into pipeline controls
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int NSTAGE    = STALL_W,
   parameter int PC_W      = 32,
   parameter int CNT_W     = 6,
   parameter int EX_IDX    = STAGE_EX,
   parameter int FLUSH_IDX = STAGE_MEM,
   parameter int PERF_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stallreq,
   input  logic              tstall_go,
   input  logic [CNT_W-1:0]  tstall_len,
   input  logic              flush_req,
   input  logic [PC_W-1:0]   flush_pc,
   output logic [NSTAGE-1:0] stall,
   output logic [NSTAGE-1:0] bubble,
   output logic              flush,
   output logic [PC_W-1:0]   new_pc,
   output logic              tstall_busy,
   output logic [PERF_W-1:0] stall_cycles
);
   state_e            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [PC_W-1:0]   pend, pend_nx;
   logic              flush_q;
   logic              hi_stall;
   logic              rise;
   logic [NSTAGE-1:0] eff_req, mask, bub;

   // stage 0 never requests; the timed stall shows up as an EX request
   assign eff_req     = (stallreq & ~NSTAGE'(1)) | (NSTAGE'(tstall_busy) << EX_IDX);
   assign hi_stall    = |stallreq[NSTAGE-1:FLUSH_IDX];
   assign rise        = flush_req & ~flush_q;
   assign flush       = state == FLUSH;
   assign tstall_busy = state == TIMED;
   assign new_pc      = flush ? pend : '0;
   assign stall       = flush ? '0 : mask;
   assign bubble      = flush ? '0 : bub;

   prio_stall_mask #(.N(NSTAGE)) u_mask (
      .req (eff_req),
      .mask(mask),
      .bub (bub)
   );

   // next state: a new flush edge beats timed stalls; only one flush is pending at a time
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pend_nx  = pend;
      case (state)
         RUN, TIMED: begin
            if (rise) begin
               state_nx = hi_stall ? FLUSH_WAIT : FLUSH;
               cnt_nx   = '0;
               pend_nx  = flush_pc;
            end else if (state == RUN) begin
               if (tstall_go && tstall_len != '0) begin
                  state_nx = TIMED;
                  cnt_nx   = tstall_len;
               end
            end else begin
               cnt_nx   = cnt - 1'b1;
               state_nx = cnt == CNT_W'(1) ? RUN : TIMED;
            end
         end
         FLUSH_WAIT: state_nx = hi_stall ? FLUSH_WAIT : FLUSH;
         default:    state_nx = RUN;
      endcase
   end

   // state, pending PC, flush edge history and saturating stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         cnt          <= '0;
         pend         <= '0;
         flush_q      <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         pend    <= pend_nx;
         flush_q <= flush_req;
         if (stall[0] && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed per-cycle vectors scored against a queue of hand-computed expectations
module tb_pipe_hazard_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stallreq = '0;
   logic        tstall_go = 1'b0;
   logic [5:0]  tstall_len = '0;
   logic        flush_req = 1'b0;
   logic [31:0] flush_pc = '0;
   logic [5:0]  stall, bubble;
   logic        flush, tstall_busy;
   logic [31:0] new_pc, stall_cycles;

   typedef struct {
      string       tag;
      logic [5:0]  st;
      logic [5:0]  bb;
      logic        fl;
      logic [31:0] pc;
      logic        busy;
      logic [31:0] sc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          passed = 0;
   logic [31:0] sc_acc = '0;

   pipe_hazard_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .stallreq    (stallreq),
      .tstall_go   (tstall_go),
      .tstall_len  (tstall_len),
      .flush_req   (flush_req),
      .flush_pc    (flush_pc),
      .stall       (stall),
      .bubble      (bubble),
      .flush       (flush),
      .new_pc      (new_pc),
      .tstall_busy (tstall_busy),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // one cycle of stimulus plus the outputs expected during that cycle
   task automatic step(input string tag, input logic r, input logic [5:0] sr, input logic go,
                       input logic [5:0] len, input logic fr, input logic [31:0] fpc,
                       input logic [5:0] st, input logic [5:0] bb, input logic fl,
                       input logic [31:0] pc, input logic busy);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; stallreq = sr; tstall_go = go; tstall_len = len; flush_req = fr; flush_pc = fpc;
      e.tag = tag; e.st = st; e.bb = bb; e.fl = fl; e.pc = pc; e.busy = busy; e.sc = sc_acc;
      q.push_back(e);
      sc_acc = r ? 32'd0 : sc_acc + {31'd0, st[0]};
   endtask

   // monitor: mid-cycle sample against the oldest queued expectation
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if ({stall, bubble, flush, new_pc, tstall_busy, stall_cycles} ===
             {e.st, e.bb, e.fl, e.pc, e.busy, e.sc})
            passed++;
         else
            $display("FAIL %s: got stall=%b bubble=%b flush=%b pc=%h busy=%b sc=%0d, want stall=%b bubble=%b flush=%b pc=%h busy=%b sc=%0d",
                     e.tag, stall, bubble, flush, new_pc, tstall_busy, stall_cycles,
                     e.st, e.bb, e.fl, e.pc, e.busy, e.sc);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      //   tag          r  stallreq  go len fr pc            stall      bubble     fl pc            busy
      step("reset",     1, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      step("idle",      0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      step("ex_req",    0, 6'b000100, 0, 0, 0, 32'h0,       6'b000111, 6'b001000, 0, 32'h0,       0);
      step("id_mem",    0, 6'b001010, 0, 0, 0, 32'h0,       6'b001111, 6'b010000, 0, 32'h0,       0);
      step("bit0_ign",  0, 6'b000001, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      step("top_req",   0, 6'b100000, 0, 0, 0, 32'h0,       6'b111111, 6'b000000, 0, 32'h0,       0);
      step("id_only",   0, 6'b000010, 0, 0, 0, 32'h0,       6'b000011, 6'b000100, 0, 32'h0,       0);
      // timed stall of 3
      step("t3_go",     0, 6'b000000, 1, 3, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      step("t3_c1",     0, 6'b000000, 0, 0, 0, 32'h0,       6'b000111, 6'b001000, 0, 32'h0,       1);
      step("t3_c2",     0, 6'b000000, 0, 0, 0, 32'h0,       6'b000111, 6'b001000, 0, 32'h0,       1);
      step("t3_c3",     0, 6'b000000, 0, 0, 0, 32'h0,       6'b000111, 6'b001000, 0, 32'h0,       1);
      step("t3_done",   0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      // zero length ignored; go while timed ignored
      step("t0_go",     0, 6'b000000, 1, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      step("t0_none",   0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      step("t2_go",     0, 6'b000000, 1, 2, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      step("t2_regos",  0, 6'b000000, 1, 5, 0, 32'h0,       6'b000111, 6'b001000, 0, 32'h0,       1);
      step("t2_c2",     0, 6'b000000, 0, 0, 0, 32'h0,       6'b000111, 6'b001000, 0, 32'h0,       1);
      step("t2_done",   0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      // flush in RUN, held high
      step("f_req",     0, 6'b000000, 0, 0, 1, 32'hBFC00380, 6'b000000, 6'b000000, 0, 32'h0,       0);
      step("f_strobe",  0, 6'b000100, 0, 0, 1, 32'h0,       6'b000000, 6'b000000, 1, 32'hBFC00380, 0);
      step("f_held",    0, 6'b000000, 0, 0, 1, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      step("f_low",     0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      // flush deferred behind a MEM stall
      step("w_c1",      0, 6'b001000, 0, 0, 1, 32'h12345678, 6'b001111, 6'b010000, 0, 32'h0,       0);
      step("w_c2",      0, 6'b001000, 0, 0, 0, 32'hDEADBEEF, 6'b001111, 6'b010000, 0, 32'h0,       0);
      step("w_c3",      0, 6'b001000, 0, 0, 0, 32'hDEADBEEF, 6'b001111, 6'b010000, 0, 32'h0,       0);
      step("w_c4",      0, 6'b001000, 0, 0, 1, 32'hDEADBEEF, 6'b001111, 6'b010000, 0, 32'h0,       0);
      step("w_drop",    0, 6'b000000, 0, 0, 1, 32'hDEADBEEF, 6'b000000, 6'b000000, 0, 32'h0,       0);
      step("w_flush",   0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 1, 32'h12345678, 0);
      step("w_after1",  0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      step("w_after2",  0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      // flush aborts a timed stall at count 7
      step("a_go",      0, 6'b000000, 1, 10, 0, 32'h0,      6'b000000, 6'b000000, 0, 32'h0,       0);
      step("a_c10",     0, 6'b000000, 0, 0, 0, 32'h0,       6'b000111, 6'b001000, 0, 32'h0,       1);
      step("a_c9",      0, 6'b000000, 0, 0, 0, 32'h0,       6'b000111, 6'b001000, 0, 32'h0,       1);
      step("a_c8",      0, 6'b000000, 0, 0, 0, 32'h0,       6'b000111, 6'b001000, 0, 32'h0,       1);
      step("a_c7_req",  0, 6'b000000, 0, 0, 1, 32'h80000180, 6'b000111, 6'b001000, 0, 32'h0,       1);
      step("a_flush",   0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 1, 32'h80000180, 0);
      step("a_run",     0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      // flush and tstall_go together: flush wins
      step("fg_both",   0, 6'b000000, 1, 4, 1, 32'h00001000, 6'b000000, 6'b000000, 0, 32'h0,       0);
      step("fg_flush",  0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 1, 32'h00001000, 0);
      step("fg_run",    0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      // reset during a timed stall
      step("rt_go",     0, 6'b000000, 1, 5, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      step("rt_c5",     0, 6'b000000, 0, 0, 0, 32'h0,       6'b000111, 6'b001000, 0, 32'h0,       1);
      step("rt_rst",    1, 6'b000000, 0, 0, 0, 32'h0,       6'b000111, 6'b001000, 0, 32'h0,       1);
      step("rt_clear",  0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      // reset while a flush is waiting
      step("rw_req",    0, 6'b001000, 0, 0, 1, 32'h0BAD0BAD, 6'b001111, 6'b010000, 0, 32'h0,       0);
      step("rw_rst",    1, 6'b001000, 0, 0, 0, 32'h0,       6'b001111, 6'b010000, 0, 32'h0,       0);
      step("rw_clear",  0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      step("rw_noflsh", 0, 6'b000000, 0, 0, 0, 32'h0,       6'b000000, 6'b000000, 0, 32'h0,       0);
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
